// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the fetch-stage PC generator.
//   state_e    : control states of the fetch FSM (BOOT, RUN, HALTED)
//   pc_sel_e   : which update source won the next-PC priority mux
//   PC_INC     : sequential fetch increment in bytes
//   DEFAULT_*  : default reset/trap vectors and target alignment
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_TRAP  = 3'd1,
        SEL_MRET  = 3'd2,
        SEL_FAULT = 3'd3,
        SEL_REDIR = 3'd4,
        SEL_INC   = 3'd5
    } pc_sel_e;

    localparam logic [31:0] PC_INC               = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    localparam int          DEFAULT_IALIGN       = 4;

endpackage : pc_gen_pkg

// File: rtl/pc_gen_next_sel.sv
// pc_gen_next_sel: purely combinational priority mux that picks the next PC.
// Ports:
//   state_i            current FSM state
//   pc_i, epc_i        current PC and saved exception PC
//   stall_i            pipeline stall (hold)
//   fetch_ready_i      instruction memory accepted pc this cycle
//   redirect_valid_i   taken branch/jump
//   redirect_target_i  branch/jump destination
//   trap_req_i, mret_i trap entry / trap return
//   halt_req_i         halt request (a RUN->HALTED entry cycle holds PC)
//   next_pc_o          PC for the next cycle
//   epc_we_o           capture pc_i into EPC
//   fault_o            misaligned redirect detected
//   flow_o             a trap/mret/redirect was taken this cycle
//   sel_o              winning update source
module pc_gen_next_sel
    import pc_gen_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int          IALIGN      = DEFAULT_IALIGN
) (
    input  state_e            state_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   epc_i,
    input  logic              stall_i,
    input  logic              fetch_ready_i,
    input  logic              redirect_valid_i,
    input  logic [XLEN-1:0]   redirect_target_i,
    input  logic              trap_req_i,
    input  logic              mret_i,
    input  logic              halt_req_i,
    output logic [XLEN-1:0]   next_pc_o,
    output logic              epc_we_o,
    output logic              fault_o,
    output logic              flow_o,
    output pc_sel_e           sel_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

    // True when the target is not a multiple of IALIGN.
    function automatic logic is_misaligned(input logic [XLEN-1:0] target);
        return (target & ALIGN_MASK) != {XLEN{1'b0}};
    endfunction

    logic misaligned_s;
    logic advance_ok_s;

    assign misaligned_s = is_misaligned(redirect_target_i);

    // The PC only advances in steady RUN with the fetch accepted. The cycle on
    // which a halt is entered also holds, so the halted PC is the one that
    // will be fetched again after resume.
    assign advance_ok_s = (state_i == ST_RUN) && !stall_i && fetch_ready_i && !halt_req_i;

    // Priority selection of the next PC source.
    always_comb begin
        sel_o = SEL_HOLD;
        if (state_i == ST_BOOT) begin
            sel_o = SEL_HOLD;
        end else if (trap_req_i) begin
            sel_o = SEL_TRAP;
        end else if (mret_i) begin
            sel_o = SEL_MRET;
        end else if (redirect_valid_i && misaligned_s) begin
            sel_o = SEL_FAULT;
        end else if (redirect_valid_i) begin
            sel_o = SEL_REDIR;
        end else if (advance_ok_s) begin
            sel_o = SEL_INC;
        end else begin
            sel_o = SEL_HOLD;
        end
    end

    // Decode the chosen source into next PC and side effects.
    always_comb begin
        next_pc_o = pc_i;
        epc_we_o  = 1'b0;
        fault_o   = 1'b0;
        flow_o    = 1'b0;
        case (sel_o)
            SEL_TRAP: begin
                next_pc_o = TRAP_VECTOR;
                epc_we_o  = 1'b1;
                flow_o    = 1'b1;
            end
            SEL_MRET: begin
                next_pc_o = epc_i;
                flow_o    = 1'b1;
            end
            SEL_FAULT: begin
                next_pc_o = TRAP_VECTOR;
                epc_we_o  = 1'b1;
                fault_o   = 1'b1;
                flow_o    = 1'b1;
            end
            SEL_REDIR: begin
                next_pc_o = redirect_target_i;
                flow_o    = 1'b1;
            end
            SEL_INC: begin
                // Truncation to XLEN gives the modulo-2^XLEN wrap.
                next_pc_o = pc_i + XLEN'(PC_INC);
            end
            SEL_HOLD: begin
                next_pc_o = pc_i;
            end
            default: begin
                next_pc_o = pc_i;
            end
        endcase
    end

endmodule : pc_gen_next_sel

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the RISC-V fetch stage.
// Holds the PC, EPC and the BOOT/RUN/HALTED FSM; next-PC choice comes from
// pc_gen_next_sel. All outputs are registered; updates appear one cycle later.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   stall, fetch_ready hold conditions for sequential advance
//   redirect_valid/redirect_target  taken branch/jump
//   trap_req, mret     trap entry / return
//   halt_req           level request to halt fetch
//   pc_out, pc_valid   fetch address and its valid flag
//   epc_out            saved exception PC
//   misalign_fault     one-cycle pulse after a misaligned redirect
//   halted             FSM is in HALTED
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int              IALIGN       = DEFAULT_IALIGN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              fetch_ready,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_target,
    input  logic              trap_req,
    input  logic              mret,
    input  logic              halt_req,
    output logic [XLEN-1:0]   pc_out,
    output logic              pc_valid,
    output logic [XLEN-1:0]   epc_out,
    output logic              misalign_fault,
    output logic              halted
);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic              pc_valid_q, pc_valid_d;
    logic              misalign_fault_q, misalign_fault_d;
    logic              halted_q, halted_d;

    logic [XLEN-1:0]   next_pc_s;
    logic              epc_we_s;
    logic              fault_s;
    logic              flow_s;
    pc_sel_e           sel_s;

    pc_gen_next_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .IALIGN      (IALIGN)
    ) u_next_sel (
        .state_i           (state_q),
        .pc_i              (pc_q),
        .epc_i             (epc_q),
        .stall_i           (stall),
        .fetch_ready_i     (fetch_ready),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .trap_req_i        (trap_req),
        .mret_i            (mret),
        .halt_req_i        (halt_req),
        .next_pc_o         (next_pc_s),
        .epc_we_o          (epc_we_s),
        .fault_o           (fault_s),
        .flow_o            (flow_s),
        .sel_o             (sel_s)
    );

    // FSM next state; redirects taken while HALTED never leave HALTED.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req && !flow_s) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (halt_req) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        pc_d             = next_pc_s;
        misalign_fault_d = fault_s;
        pc_valid_d       = (state_d == ST_RUN);
        halted_d         = (state_d == ST_HALTED);
        if (epc_we_s) begin
            epc_d = pc_q;
        end else begin
            epc_d = epc_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_BOOT;
            pc_q             <= RESET_VECTOR;
            epc_q            <= {XLEN{1'b0}};
            pc_valid_q       <= 1'b0;
            misalign_fault_q <= 1'b0;
            halted_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            epc_q            <= epc_d;
            pc_valid_q       <= pc_valid_d;
            misalign_fault_q <= misalign_fault_d;
            halted_q         <= halted_d;
        end
    end

    assign pc_out         = pc_q;
    assign pc_valid       = pc_valid_q;
    assign epc_out        = epc_q;
    assign misalign_fault = misalign_fault_q;
    assign halted         = halted_q;

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// tb_pc_gen: self-checking bench for pc_gen with a reference model feeding a
// scoreboard queue, plus fixed-value checks of the directed scenarios.
module tb_pc_gen;

    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam logic [31:0] TV   = 32'h0000_0100;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              fetch_ready;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_target;
    logic              trap_req;
    logic              mret;
    logic              halt_req;
    logic [XLEN-1:0]   pc_out;
    logic              pc_valid;
    logic [XLEN-1:0]   epc_out;
    logic              misalign_fault;
    logic              halted;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        valid;
        logic        fault;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: 0=BOOT 1=RUN 2=HALTED
    logic [31:0] m_pc, m_epc;
    logic        m_valid, m_fault, m_halted;
    int          m_state;

    pc_gen #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .IALIGN       (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .fetch_ready     (fetch_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_req        (trap_req),
        .mret            (mret),
        .halt_req        (halt_req),
        .pc_out          (pc_out),
        .pc_valid        (pc_valid),
        .epc_out         (epc_out),
        .misalign_fault  (misalign_fault),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock given the inputs about to be sampled.
    task automatic model_step(input logic rst, st, fr, rv, input logic [31:0] rt,
                              input logic tr, mr, hr);
        logic flow;
        flow = 1'b0;
        if (rst) begin
            m_pc = RV; m_epc = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
            m_halted = 1'b0; m_state = 0;
        end else begin
            m_fault = 1'b0;
            if (m_state != 0) begin
                if (tr) begin
                    m_epc = m_pc; m_pc = TV; flow = 1'b1;
                end else if (mr) begin
                    m_pc = m_epc; flow = 1'b1;
                end else if (rv && (rt[1:0] != 2'b00)) begin
                    m_epc = m_pc; m_pc = TV; m_fault = 1'b1; flow = 1'b1;
                end else if (rv) begin
                    m_pc = rt; flow = 1'b1;
                end else if (m_state == 1 && !st && fr && !hr) begin
                    m_pc = m_pc + 32'd4;
                end
            end
            if (m_state == 0)                 m_state = 1;
            else if (m_state == 1)            m_state = (hr && !flow) ? 2 : 1;
            else                              m_state = hr ? 2 : 1;
            m_valid  = (m_state == 1);
            m_halted = (m_state == 2);
        end
    endtask

    // Drive one cycle, push the model's expectation, then compare after the edge.
    task automatic cyc(input logic rst, st, fr, rv, input logic [31:0] rt,
                       input logic tr, mr, hr);
        exp_t e;
        reset = rst; stall = st; fetch_ready = fr; redirect_valid = rv;
        redirect_target = rt; trap_req = tr; mret = mr; halt_req = hr;
        model_step(rst, st, fr, rv, rt, tr, mr, hr);
        exp_q.push_back('{pc: m_pc, epc: m_epc, valid: m_valid, fault: m_fault, halted: m_halted});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("pc_out",         pc_out,                  e.pc);
            check("epc_out",        epc_out,                 e.epc);
            check("pc_valid",       {31'd0, pc_valid},       {31'd0, e.valid});
            check("misalign_fault", {31'd0, misalign_fault}, {31'd0, e.fault});
            check("halted",         {31'd0, halted},         {31'd0, e.halted});
        end
    endtask

    // Plain running cycle with optional stall / fetch_ready.
    task automatic run(input logic st, input logic fr);
        cyc(1'b0, st, fr, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic redir(input logic st, input logic [31:0] tgt, input logic hr);
        cyc(1'b0, st, 1'b1, 1'b1, tgt, 1'b0, 1'b0, hr);
    endtask

    initial begin
        logic r_rst, r_st, r_fr, r_rv, r_tr, r_mr, r_hr;
        logic [31:0] r_t;

        // Reset.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_valid", {31'd0, pc_valid}, 32'd0);

        // BOOT cycle then sequential fetch 0,4,8.
        run(1'b0, 1'b1);
        check("boot_pc", pc_out, 32'h0);
        check("boot_valid_after", {31'd0, pc_valid}, 32'd1);
        run(1'b0, 1'b1); check("seq_4", pc_out, 32'h4);
        run(1'b0, 1'b1); check("seq_8", pc_out, 32'h8);

        // Stall and fetch_ready=0 both hold.
        for (int i = 0; i < 3; i++) run(1'b1, 1'b1);
        check("stall_hold", pc_out, 32'h8);
        run(1'b0, 1'b1); check("stall_release", pc_out, 32'hC);
        for (int i = 0; i < 3; i++) run(1'b0, 1'b0);
        check("fr_hold", pc_out, 32'hC);
        run(1'b0, 1'b1); check("fr_release", pc_out, 32'h10);

        // Halt at 0x10, resume, advance to 0x14.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("halt_pc", pc_out, 32'h10);
        check("halt_flag", {31'd0, halted}, 32'd1);
        run(1'b0, 1'b1); check("resume_pc", pc_out, 32'h10);
        run(1'b0, 1'b1); check("resume_adv", pc_out, 32'h14);

        // Redirect during stall, then misaligned redirect.
        redir(1'b1, 32'h40, 1'b0); check("redir_stall", pc_out, 32'h40);
        redir(1'b0, 32'h42, 1'b0);
        check("fault_pc", pc_out, 32'h100);
        check("fault_epc", epc_out, 32'h40);
        check("fault_pulse", {31'd0, misalign_fault}, 32'd1);
        run(1'b0, 1'b1); check("fault_clear", {31'd0, misalign_fault}, 32'd0);

        // Trap at 0x20, mret, trap+mret, mret+redirect.
        redir(1'b0, 32'h20, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("trap_pc", pc_out, 32'h100);
        check("trap_epc", epc_out, 32'h20);
        run(1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("mret_pc", pc_out, 32'h20);
        run(1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        check("trap_mret_pc", pc_out, 32'h100);
        check("trap_mret_epc", epc_out, 32'h24);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0);
        check("mret_over_redir", pc_out, 32'h24);

        // Redirect while halted keeps HALTED; reset while halted.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        redir(1'b0, 32'h80, 1'b1);
        check("halt_redir_pc", pc_out, 32'h80);
        check("halt_redir_state", {31'd0, halted}, 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("halt_rst_pc", pc_out, 32'h0);
        check("halt_rst_flag", {31'd0, halted}, 32'd0);
        check("halt_rst_epc", epc_out, 32'h0);
        run(1'b0, 1'b1); run(1'b0, 1'b1);
        check("post_rst_seq", pc_out, 32'h4);

        // Wrap at top of address space.
        redir(1'b0, 32'hFFFF_FFFC, 1'b0);
        run(1'b0, 1'b1); check("wrap", pc_out, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r_rst = ($urandom_range(0, 49) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_fr  = ($urandom_range(0, 4) != 0);
            r_rv  = ($urandom_range(0, 5) == 0);
            r_t   = $urandom;
            if ($urandom_range(0, 1) == 0) r_t[1:0] = 2'b00;
            r_tr  = ($urandom_range(0, 15) == 0);
            r_mr  = ($urandom_range(0, 11) == 0);
            r_hr  = ($urandom_range(0, 7) == 0);
            cyc(r_rst, r_st, r_fr, r_rv, r_t, r_tr, r_mr, r_hr);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_pc_gen
